// File: rtl/rv_decode_stage.sv
// Registered RV instruction-decode stage: valid/ready on both sides, flush,
// and a single-bubble load-use interlock with a saturating stall counter.
module rv_decode_stage #(
    parameter int XLEN           = 64,
    parameter int CNT_W          = 16,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_branch,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_mem_to_reg,
    output logic             out_alu_src,
    output logic             out_reg_write,
    output logic [1:0]       out_alu_op,
    output logic [3:0]       out_alu_ctl,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [2:0] LDST_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    typedef struct packed {
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            reg_write;
        logic [1:0]      alu_op;
        logic [3:0]      alu_ctl;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    bundle_t         dec;
    bundle_t         bundle_q;
    logic            dec_is_load;
    logic            ld_pending;
    logic [4:0]      ld_rd;
    logic            hazard;
    logic            drain;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec         = '0;
        dec_is_load = 1'b0;
        case (opcode)
            OP_R: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alu_ctl = 4'b0010;
                    {7'b0100000, 3'b000}: dec.alu_ctl = 4'b0110;
                    {7'b0000000, 3'b111}: dec.alu_ctl = 4'b0000;
                    {7'b0000000, 3'b110}: dec.alu_ctl = 4'b0001;
                    default:              dec.illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
                dec.imm       = imm_i;
                case (funct3)
                    3'b000:  dec.alu_ctl = 4'b0010;
                    3'b111:  dec.alu_ctl = 4'b0000;
                    3'b110:  dec.alu_ctl = 4'b0001;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LD: begin
                dec.rs1        = in_instr[19:15];
                dec.rd         = in_instr[11:7];
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_ctl    = 4'b0010;
                dec.imm        = imm_i;
                dec_is_load    = 1'b1;
                dec.illegal    = (funct3 != LDST_F3);
            end
            OP_ST: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctl   = 4'b0010;
                dec.imm       = imm_s;
                dec.illegal   = (funct3 != LDST_F3);
            end
            OP_BR: begin
                dec.rs1     = in_instr[19:15];
                dec.rs2     = in_instr[24:20];
                dec.branch  = 1'b1;
                dec.alu_op  = 2'b01;
                dec.alu_ctl = 4'b0110;
                dec.imm     = imm_b;
                dec.illegal = (funct3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        // An unsupported encoding carries nothing but the illegal flag downstream.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_is_load = 1'b0;
        end
    end

    // Unused register fields decode to 0 and ld_rd is never 0 while pending,
    // so a plain equality is enough to detect a real dependency.
    assign hazard   = LOAD_USE_STALL && ld_pending && in_valid &&
                      ((dec.rs1 == ld_rd) || (dec.rs2 == ld_rd));
    assign drain    = ~out_valid | out_ready;
    assign in_ready = drain & ~hazard & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here has a reset value; state uses non-blocking assignment only.
        if (!rst_n) begin
            out_valid   <= 1'b0;
            bundle_q    <= '0;
            out_pc      <= '0;
            out_next_pc <= '0;
            ld_pending  <= 1'b0;
            ld_rd       <= '0;
            stall_count <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            ld_pending <= 1'b0;
        end else if (drain) begin
            if (hazard) begin
                out_valid  <= 1'b0;
                ld_pending <= 1'b0;
                if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
            end else if (in_valid) begin
                out_valid   <= 1'b1;
                bundle_q    <= dec;
                out_pc      <= in_pc;
                out_next_pc <= in_pc + XLEN'(4);
                ld_pending  <= dec_is_load && (dec.rd != 5'd0);
                ld_rd       <= dec.rd;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_branch     = bundle_q.branch;
    assign out_mem_read   = bundle_q.mem_read;
    assign out_mem_write  = bundle_q.mem_write;
    assign out_mem_to_reg = bundle_q.mem_to_reg;
    assign out_alu_src    = bundle_q.alu_src;
    assign out_reg_write  = bundle_q.reg_write;
    assign out_alu_op     = bundle_q.alu_op;
    assign out_alu_ctl    = bundle_q.alu_ctl;
    assign out_rs1        = bundle_q.rs1;
    assign out_rs2        = bundle_q.rs2;
    assign out_rd         = bundle_q.rd;
    assign out_imm        = bundle_q.imm;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: mnemonic-level reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_rv_decode_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_branch;
    logic             out_mem_read;
    logic             out_mem_write;
    logic             out_mem_to_reg;
    logic             out_alu_src;
    logic             out_reg_write;
    logic [1:0]       out_alu_op;
    logic [3:0]       out_alu_ctl;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] stall_count;

    rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .LOAD_USE_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_next_pc(out_next_pc),
        .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
        .out_alu_op(out_alu_op), .out_alu_ctl(out_alu_ctl),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_illegal(out_illegal), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_ADDI, M_ANDI, M_ORI,
                  M_LD, M_SD, M_BEQ, M_ILL} mnem_e;

    typedef struct packed {
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  alu_op;
        logic [3:0]  alu_ctl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        illegal;
    } bundle_t;

    function automatic mnem_e classify(input logic [31:0] ins);
        int op, f3, f7;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        if (op == 'h33 && f7 == 0    && f3 == 0) return M_ADD;
        if (op == 'h33 && f7 == 'h20 && f3 == 0) return M_SUB;
        if (op == 'h33 && f7 == 0    && f3 == 7) return M_AND;
        if (op == 'h33 && f7 == 0    && f3 == 6) return M_OR;
        if (op == 'h13 && f3 == 0) return M_ADDI;
        if (op == 'h13 && f3 == 7) return M_ANDI;
        if (op == 'h13 && f3 == 6) return M_ORI;
        if (op == 'h03 && f3 == 3) return M_LD;
        if (op == 'h23 && f3 == 3) return M_SD;
        if (op == 'h63 && f3 == 0) return M_BEQ;
        return M_ILL;
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ins);
        bundle_t b;
        mnem_e   m;
        longint  i_imm, s_imm, b_imm;
        logic [11:0] s_raw;
        logic [12:0] b_raw;
        b = '0;
        m = classify(ins);
        i_imm = longint'(ins[31:20]);
        if (ins[31]) i_imm = i_imm - 4096;
        s_raw = {ins[31:25], ins[11:7]};
        s_imm = longint'(s_raw);
        if (ins[31]) s_imm = s_imm - 4096;
        b_raw = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        b_imm = longint'(b_raw);
        if (ins[31]) b_imm = b_imm - 8192;
        case (m)
            M_ADD, M_SUB, M_AND, M_OR: begin
                b.reg_write = 1; b.alu_op = 2;
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
            end
            M_ADDI, M_ANDI, M_ORI: begin
                b.alu_src = 1; b.reg_write = 1; b.alu_op = 3;
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = i_imm;
            end
            M_LD: begin
                b.mem_read = 1; b.mem_to_reg = 1; b.alu_src = 1; b.reg_write = 1;
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = i_imm;
            end
            M_SD: begin
                b.mem_write = 1; b.alu_src = 1;
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.imm = s_imm;
            end
            M_BEQ: begin
                b.branch = 1; b.alu_op = 1;
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.imm = b_imm;
            end
            default: b.illegal = 1;
        endcase
        case (m)
            M_ADD, M_ADDI, M_LD, M_SD: b.alu_ctl = 4'd2;
            M_SUB, M_BEQ:              b.alu_ctl = 4'd6;
            M_AND, M_ANDI:             b.alu_ctl = 4'd0;
            M_OR, M_ORI:               b.alu_ctl = 4'd1;
            default:                   b.alu_ctl = 4'd0;
        endcase
        return b;
    endfunction

    logic             m_valid = 1'b0;
    logic             m_pend  = 1'b0;
    logic [4:0]       m_ld_rd = '0;
    int               m_cnt   = 0;
    bundle_t          m_b     = '0;
    logic [63:0]      m_pc    = '0;
    logic [63:0]      m_npc   = '0;

    function automatic logic m_hazard();
        bundle_t d;
        d = model_decode(in_instr);
        return m_pend && in_valid && (d.rs1 == m_ld_rd || d.rs2 == m_ld_rd);
    endfunction

    function automatic logic exp_in_ready();
        return (!m_valid || out_ready) && !m_hazard() && !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
            m_ld_rd <= '0;
            m_cnt   <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
        end else if (!m_valid || out_ready) begin
            if (m_hazard()) begin
                m_valid <= 1'b0;
                m_pend  <= 1'b0;
                m_cnt   <= (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
            end else if (in_valid) begin
                m_valid <= 1'b1;
                m_b     <= model_decode(in_instr);
                m_pc    <= in_pc;
                m_npc   <= in_pc + 64'd4;
                m_pend  <= (classify(in_instr) == M_LD) && (in_instr[11:7] != 5'd0);
                m_ld_rd <= in_instr[11:7];
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out_valid", out_valid, 64'd0);
            check("reset_stall_count", stall_count, 64'd0);
        end else begin
            check("in_ready", in_ready, exp_in_ready());
            check("out_valid", out_valid, m_valid);
            check("stall_count", stall_count, m_cnt);
            if (m_valid) begin
                check("out_pc", out_pc, m_pc);
                check("out_next_pc", out_next_pc, m_npc);
                check("out_illegal", out_illegal, m_b.illegal);
                check("ctrl_bits", {out_branch, out_mem_read, out_mem_write, out_mem_to_reg,
                                    out_alu_src, out_reg_write},
                      {m_b.branch, m_b.mem_read, m_b.mem_write, m_b.mem_to_reg,
                       m_b.alu_src, m_b.reg_write});
                if (!m_b.illegal) begin
                    check("out_alu_op", out_alu_op, m_b.alu_op);
                    check("out_alu_ctl", out_alu_ctl, m_b.alu_ctl);
                    check("out_regs", {out_rs1, out_rs2, out_rd}, {m_b.rs1, m_b.rs2, m_b.rd});
                    check("out_imm", out_imm, m_b.imm);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] ins, input logic [63:0] pc, output int waits);
        logic acc;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = 1'b1;
        flush     = 1'b0;
        waits     = 0;
        for (int i = 0; i < 20; i++) begin
            acc = exp_in_ready();
            @(posedge clk); #1;
            if (acc) return;
            waits++;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: instruction 0x%08h not accepted within 20 cycles", ins);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  a, b, d;
        int          k;
        r = $urandom;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        case (k)
            0, 1: begin
                case ($urandom_range(0, 3))
                    0:       return {7'h00, b, a, 3'd0, d, 7'h33};
                    1:       return {7'h20, b, a, 3'd0, d, 7'h33};
                    2:       return {7'h00, b, a, 3'd7, d, 7'h33};
                    default: return {7'h00, b, a, 3'd6, d, 7'h33};
                endcase
            end
            2:    return {r[31:20], a, (r[0] ? 3'd7 : (r[1] ? 3'd6 : 3'd0)), d, 7'h13};
            3, 4: return {r[31:20], a, 3'd3, d, 7'h03};
            5:    return {r[31:25], b, a, 3'd3, r[11:7], 7'h23};
            6:    return {r[31:25], b, a, 3'd0, r[11:7], 7'h63};
            7:    return {r[31:25], b, a, r[14:12], d, 7'h33};
            8:    return {r[31:20], a, 3'd2, d, 7'h03};
            default: return r;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Pin the model against hand-computed encodings.
        check("model_beq_imm", model_decode(32'hFE208EE3).imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("model_sd_imm", model_decode(32'h0050B823).imm, 64'h10);
        check("model_sub_ctl", model_decode(32'h402081B3).alu_ctl, 64'd6);
        check("model_ld_class", model_decode(32'h0080B283).mem_to_reg, 64'd1);
        check("model_ones_illegal", model_decode(32'hFFFFFFFF).illegal, 64'd1);

        // add / sub
        send(32'h002081B3, 64'h100, w);
        check("add_valid", out_valid, 64'd1);
        check("add_alu_op", out_alu_op, 64'b10);
        check("add_alu_ctl", out_alu_ctl, 64'b0010);
        check("add_regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
        check("add_reg_write", out_reg_write, 64'd1);
        check("add_imm", out_imm, 64'd0);
        send(32'h402081B3, 64'h104, w);
        check("sub_alu_ctl", out_alu_ctl, 64'b0110);

        // load-use: exactly one bubble
        send(32'h0080B283, 64'h200, w);
        check("ld_imm", out_imm, 64'd8);
        check("ld_rd", out_rd, 64'd5);
        send(32'h00228333, 64'h204, w);
        check("ld_use_waits", w, 64'd1);
        check("ld_use_add_rd", out_rd, 64'd6);
        check("ld_use_stall_count", stall_count, 64'd1);
        idle(2);

        // branch and store
        send(32'hFE208EE3, 64'h1000, w);
        check("beq_branch", out_branch, 64'd1);
        check("beq_alu_ctl", out_alu_ctl, 64'b0110);
        check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_next_pc", out_next_pc, 64'h1004);
        send(32'h0050B823, 64'h1004, w);
        check("sd_mem_write", out_mem_write, 64'd1);
        check("sd_imm", out_imm, 64'h10);
        check("sd_rs2", out_rs2, 64'd5);

        // illegal word and PC wrap
        send(32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, w);
        check("ill_flag", out_illegal, 64'd1);
        check("ill_ctrl", {out_branch, out_mem_read, out_mem_write, out_mem_to_reg,
                           out_alu_src, out_reg_write}, 64'd0);
        check("ill_next_pc_wrap", out_next_pc, 64'd0);

        // back-pressure, then flush
        send(32'h002081B3, 64'h300, w);
        in_instr  = 32'h00A00093;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_in_ready", in_ready, 64'd0);
            check("hold_out_rd", out_rd, 64'd3);
            check("hold_out_valid", out_valid, 64'd1);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_out_valid", out_valid, 64'd0);
        flush = 1'b0;

        // flush during a load-use hazard takes no count
        send(32'h0080B283, 64'h400, w);
        in_instr = 32'h00228333;
        flush    = 1'b1;
        @(posedge clk); #1;
        send(32'h00228333, 64'h404, w);
        check("flushed_hazard_waits", w, 64'd0);
        check("flushed_hazard_count", stall_count, 64'd1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = rand_instr();
            in_pc     = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                    : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        idle(2);

        // drive the counter into saturation
        for (int i = 0; i < 16; i++) begin
            send(32'h0080B283, 64'h500, w);
            send(32'h00228333, 64'h504, w);
        end
        idle(2);
        check("stall_count_saturated", stall_count, 64'hF);

        // async reset while a load is pending
        send(32'h0080B283, 64'h600, w);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 64'd0);
        check("async_rst_stall_count", stall_count, 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        send(32'h00228333, 64'h604, w);
        check("post_rst_no_bubble", w, 64'd0);
        check("post_rst_add_rd", out_rd, 64'd6);
        check("post_rst_stall_count", stall_count, 64'd0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
